// File: rtl/fetch_miss_controller.sv
// Fetch-stage I-cache miss sequencer: freezes the PC on a miss, refills the line
// from memory, and replays any branch redirect that arrived while the refill ran.
module fetch_miss_controller #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              Hit,
  input  logic              PCSource,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              stall_pc,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_index,
  output logic [ADDR_W-1:0] fill_data,
  output logic              fill_tag_valid,
  output logic [15:0]       miss_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_line_addr;
  logic [IDX_W-1:0]    r_beat;
  logic                r_pending;
  logic [ADDR_W-1:0]   r_redirect_target;
  logic [15:0]         r_miss_count;
  logic                w_miss;

  // Next-state and output decode; reset forces every output low in its own cycle.
  always_comb begin
    w_next_state    = r_state;
    w_miss          = 1'b0;
    stall_pc        = 1'b0;
    redirect        = 1'b0;
    redirect_target = r_redirect_target;
    mem_req         = 1'b0;
    mem_addr        = '0;
    fill_we         = 1'b0;
    fill_index      = '0;
    fill_data       = '0;
    fill_tag_valid  = 1'b0;
    miss_count      = r_miss_count;

    case (r_state)
      S_IDLE: begin
        // A same-cycle redirect wins over the miss: the fetched line is discarded.
        if (!Hit && !PCSource) begin
          stall_pc     = 1'b1;
          w_miss       = 1'b1;
          w_next_state = S_REQ;
        end else begin
          stall_pc = 1'b0;
        end
      end
      S_REQ: begin
        stall_pc = 1'b1;
        mem_req  = 1'b1;
        mem_addr = r_line_addr;
        if (mem_ack) begin
          w_next_state = S_FILL;
        end else begin
          w_next_state = S_REQ;
        end
      end
      S_FILL: begin
        stall_pc = 1'b1;
        if (mem_rvalid) begin
          fill_we    = 1'b1;
          fill_index = r_beat;
          fill_data  = mem_rdata;
          if (r_beat == LAST_BEAT) begin
            fill_tag_valid = 1'b1;
            w_next_state   = S_DONE;
          end else begin
            w_next_state = S_FILL;
          end
        end else begin
          w_next_state = S_FILL;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        // A live redirect here is newer than anything held during the refill.
        if (PCSource) begin
          redirect        = 1'b1;
          redirect_target = BranchTarget;
          stall_pc        = 1'b0;
        end else if (r_pending) begin
          redirect = 1'b1;
          stall_pc = 1'b0;
        end else begin
          stall_pc = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    if (reset) begin
      w_next_state    = S_IDLE;
      w_miss          = 1'b0;
      stall_pc        = 1'b0;
      redirect        = 1'b0;
      redirect_target = '0;
      mem_req         = 1'b0;
      mem_addr        = '0;
      fill_we         = 1'b0;
      fill_index      = '0;
      fill_data       = '0;
      fill_tag_valid  = 1'b0;
      miss_count      = '0;
    end else begin
      miss_count = r_miss_count;
    end
  end

  // State, refill bookkeeping, held redirect and performance counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_line_addr       <= '0;
      r_beat            <= '0;
      r_pending         <= 1'b0;
      r_redirect_target <= '0;
      r_miss_count      <= '0;
    end else begin
      r_state <= w_next_state;

      if (w_miss) begin
        r_line_addr <= {fetch_pc[ADDR_W-1:IDX_W+2], {(IDX_W+2){1'b0}}};
        if (r_miss_count != 16'hFFFF) begin
          r_miss_count <= r_miss_count + 16'd1;
        end
      end

      if (r_state == S_REQ && mem_ack) begin
        r_beat <= '0;
      end else if (r_state == S_FILL && mem_rvalid) begin
        r_beat <= r_beat + IDX_W'(1);
      end

      if ((r_state == S_REQ || r_state == S_FILL) && PCSource) begin
        r_pending         <= 1'b1;
        r_redirect_target <= BranchTarget;
      end else if (r_state == S_DONE) begin
        r_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_miss_controller.sv
// Directed self-checking bench for fetch_miss_controller.
module tb_fetch_miss_controller;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 2;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] fetch_pc;
  logic              Hit;
  logic              PCSource;
  logic [ADDR_W-1:0] BranchTarget;
  logic              stall_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [ADDR_W-1:0] mem_rdata;
  logic              fill_we;
  logic [IDX_W-1:0]  fill_index;
  logic [ADDR_W-1:0] fill_data;
  logic              fill_tag_valid;
  logic [15:0]       miss_count;

  int checks = 0;
  int errors = 0;

  fetch_miss_controller #(.ADDR_W(ADDR_W), .LINE_WORDS(4), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .Hit(Hit),
    .PCSource(PCSource), .BranchTarget(BranchTarget), .stall_pc(stall_pc),
    .redirect(redirect), .redirect_target(redirect_target), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .fill_we(fill_we), .fill_index(fill_index),
    .fill_data(fill_data), .fill_tag_valid(fill_tag_valid), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here, checks follow #2 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait miss and refill; returns in the IDLE cycle after DONE.
  task automatic do_miss(input logic [ADDR_W-1:0] addr);
    cyc(); fetch_pc = addr; Hit = 1'b0;
    cyc(); mem_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      cyc(); mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0B00 + 32'(b);
    end
    cyc(); mem_rvalid = 1'b0; Hit = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; Hit = 1'b0; PCSource = 1'b0; fetch_pc = 32'h0000_0010;
    BranchTarget = '0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    cyc(); cyc(); #2;
    checks++;
    if (stall_pc !== 1'b0 || mem_req !== 1'b0 || redirect !== 1'b0 ||
        fill_we !== 1'b0 || fill_tag_valid !== 1'b0 || miss_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b req=%b redir=%b we=%b tag=%b cnt=%h, expected all 0",
               stall_pc, mem_req, redirect, fill_we, fill_tag_valid, miss_count);
    end
    cyc(); reset = 1'b0; Hit = 1'b1;
  endtask

  task automatic test_hit();
    for (int i = 0; i < 20; i++) begin
      cyc(); fetch_pc = 32'h0000_1000 + 32'(4 * i); #2;
      checks++;
      if (stall_pc !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL hit_no_stall[%0d]: stall=%b req=%b, expected 0 0", i, stall_pc, mem_req);
      end
    end
    checks++;
    if (miss_count !== 16'h0000) begin
      errors++;
      $display("FAIL hit_miss_count: got %h expected 0000", miss_count);
    end
  endtask

  task automatic test_miss();
    cyc(); fetch_pc = 32'h0000_0048; Hit = 1'b0; #2;
    checks++;
    if (stall_pc !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL miss_detect: stall=%b req=%b, expected 1 0", stall_pc, mem_req);
    end
    for (int w = 0; w < 3; w++) begin
      cyc(); mem_ack = (w == 2); #2;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0040 || stall_pc !== 1'b1) begin
        errors++;
        $display("FAIL miss_req[%0d]: req=%b addr=%h stall=%b, expected 1 00000040 1",
                 w, mem_req, mem_addr, stall_pc);
      end
    end
    cyc(); mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_00A0; #2;
    checks++;
    if (fill_we !== 1'b1 || fill_index !== 2'd0 || fill_data !== 32'h0000_00A0 ||
        fill_tag_valid !== 1'b0 || mem_req !== 1'b0 || stall_pc !== 1'b1) begin
      errors++;
      $display("FAIL miss_beat0: we=%b idx=%0d data=%h tag=%b req=%b stall=%b, expected 1 0 a0 0 0 1",
               fill_we, fill_index, fill_data, fill_tag_valid, mem_req, stall_pc);
    end
    cyc(); mem_rvalid = 1'b0; #2;
    checks++;
    if (fill_we !== 1'b0 || fill_tag_valid !== 1'b0 || stall_pc !== 1'b1) begin
      errors++;
      $display("FAIL miss_gap: we=%b tag=%b stall=%b, expected 0 0 1", fill_we, fill_tag_valid, stall_pc);
    end
    for (int b = 1; b < 4; b++) begin
      cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h0000_00A0 + 32'(b); #2;
      checks++;
      if (fill_we !== 1'b1 || fill_index !== 2'(b) || fill_data !== (32'h0000_00A0 + 32'(b)) ||
          fill_tag_valid !== (b == 3) || stall_pc !== 1'b1) begin
        errors++;
        $display("FAIL miss_beat%0d: we=%b idx=%0d data=%h tag=%b stall=%b, expected 1 %0d %h %b 1",
                 b, fill_we, fill_index, fill_data, fill_tag_valid, stall_pc, b,
                 32'h0000_00A0 + 32'(b), (b == 3));
      end
    end
    cyc(); mem_rvalid = 1'b0; Hit = 1'b1; #2;
    checks++;
    if (stall_pc !== 1'b1 || redirect !== 1'b0 || fill_we !== 1'b0) begin
      errors++;
      $display("FAIL miss_done: stall=%b redir=%b we=%b, expected 1 0 0", stall_pc, redirect, fill_we);
    end
    cyc(); #2;
    checks++;
    if (stall_pc !== 1'b0 || miss_count !== 16'd1) begin
      errors++;
      $display("FAIL miss_resume: stall=%b cnt=%0d, expected 0 1", stall_pc, miss_count);
    end
  endtask

  task automatic test_redirect_mid_fill();
    cyc(); fetch_pc = 32'h0000_1004; Hit = 1'b0;
    cyc(); mem_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      cyc(); mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0C00 + 32'(b);
      PCSource = (b == 0 || b == 2);
      BranchTarget = (b == 0) ? 32'h0000_0100 : 32'h0000_0200;
      #2;
      checks++;
      if (redirect !== 1'b0 || stall_pc !== 1'b1) begin
        errors++;
        $display("FAIL redir_fill_beat%0d: redir=%b stall=%b, expected 0 1", b, redirect, stall_pc);
      end
    end
    cyc(); mem_rvalid = 1'b0; PCSource = 1'b0; BranchTarget = 32'h0000_0FFC; Hit = 1'b1; #2;
    checks++;
    if (redirect !== 1'b1 || redirect_target !== 32'h0000_0200 || stall_pc !== 1'b0) begin
      errors++;
      $display("FAIL redir_replay: redir=%b target=%h stall=%b, expected 1 00000200 0",
               redirect, redirect_target, stall_pc);
    end
    cyc(); #2;
    checks++;
    if (redirect !== 1'b0 || stall_pc !== 1'b0 || miss_count !== 16'd2) begin
      errors++;
      $display("FAIL redir_after: redir=%b stall=%b cnt=%0d, expected 0 0 2", redirect, stall_pc, miss_count);
    end
  endtask

  task automatic test_miss_with_branch();
    cyc(); fetch_pc = 32'h0000_2000; Hit = 1'b0; PCSource = 1'b1; BranchTarget = 32'h0000_0080; #2;
    checks++;
    if (stall_pc !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL branch_wins: stall=%b req=%b, expected 0 0", stall_pc, mem_req);
    end
    cyc(); Hit = 1'b1; PCSource = 1'b0; fetch_pc = 32'h0000_0080; #2;
    checks++;
    if (mem_req !== 1'b0 || stall_pc !== 1'b0 || miss_count !== 16'd2) begin
      errors++;
      $display("FAIL branch_no_refill: req=%b stall=%b cnt=%0d, expected 0 0 2", mem_req, stall_pc, miss_count);
    end
  endtask

  task automatic test_reset_mid_fill();
    cyc(); fetch_pc = 32'h0000_3008; Hit = 1'b0;
    cyc(); mem_ack = 1'b1;
    cyc(); mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0D00;
    PCSource = 1'b1; BranchTarget = 32'h0000_0300;
    cyc(); PCSource = 1'b0; mem_rdata = 32'h0000_0D01;
    cyc(); reset = 1'b1; mem_rdata = 32'h0000_0D02; #2;
    checks++;
    if (stall_pc !== 1'b0 || redirect !== 1'b0 || redirect_target !== 32'h0 || mem_req !== 1'b0 ||
        mem_addr !== 32'h0 || fill_we !== 1'b0 || fill_index !== 2'd0 || fill_data !== 32'h0 ||
        fill_tag_valid !== 1'b0 || miss_count !== 16'h0) begin
      errors++;
      $display("FAIL rst_fill_cycle: stall=%b redir=%b tgt=%h req=%b addr=%h we=%b idx=%0d data=%h tag=%b cnt=%h, expected all 0",
               stall_pc, redirect, redirect_target, mem_req, mem_addr, fill_we, fill_index,
               fill_data, fill_tag_valid, miss_count);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(); reset = 1'b0; Hit = 1'b1; mem_rdata = 32'h0000_0D03; #2;
      checks++;
      if (stall_pc !== 1'b0 || redirect !== 1'b0 || redirect_target !== 32'h0 || mem_req !== 1'b0 ||
          fill_we !== 1'b0 || fill_tag_valid !== 1'b0 || miss_count !== 16'h0) begin
        errors++;
        $display("FAIL rst_fill_after[%0d]: stall=%b redir=%b tgt=%h req=%b we=%b tag=%b cnt=%h, expected all 0",
                 k, stall_pc, redirect, redirect_target, mem_req, fill_we, fill_tag_valid, miss_count);
      end
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_saturation();
    cyc();
    force dut.r_miss_count = 16'hFFFE;
    #1;
    release dut.r_miss_count;
    #1;
    checks++;
    if (miss_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preload: got %h expected fffe", miss_count);
    end
    do_miss(32'h0000_4000);
    #2;
    checks++;
    if (miss_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach: got %h expected ffff", miss_count);
    end
    do_miss(32'h0000_5000);
    do_miss(32'h0000_6000);
    #2;
    checks++;
    if (miss_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h expected ffff", miss_count);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_redirect_mid_fill();
    test_miss_with_branch();
    test_reset_mid_fill();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
